ycbcr_skin_centroid: RTL and testbench

- Downstream stage of the RGB-to-YCbCr converter.
- Thresholds each incoming YCbCr pixel on Cb/Cr into a binary skin mask. The mask is output as a 24-bit pixel with delayed sync signals, for display.
- Accumulates per-frame mask moments: m00 (pixel count), m10 (sum of x), m01 (sum of y).
- At frame end, a sequential restoring divider computes the centroid of the mask.

---
 rtl/ycbcr_skin_centroid.sv | 167 ++++++++++++++++
 tb/tb_ycbcr_skin_centroid.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr_skin_centroid.sv
// Skin-colour mask on Cb/Cr with per-frame moment accumulation and a
// sequential restoring divider that publishes the mask centroid at frame end.
module ycbcr_skin_centroid #(
  parameter logic [7:0] CB_MIN = 8'd77,
  parameter logic [7:0] CB_MAX = 8'd127,
  parameter logic [7:0] CR_MIN = 8'd133,
  parameter logic [7:0] CR_MAX = 8'd173
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de_in,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic [23:0] pixel_YCbCr,
  output logic        de_out,
  output logic        h_sync_out,
  output logic        v_sync_out,
  output logic [23:0] pixel_mask,
  output logic [10:0] centroid_x,
  output logic [10:0] centroid_y,
  output logic        centroid_valid,
  output logic        object_found,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  logic [7:0]  cb;
  logic [7:0]  cr;
  logic        mask;
  logic        frame_end;
  logic        de_fall;

  logic [10:0] x_reg;
  logic [10:0] y_reg;
  logic [21:0] m00_reg;
  logic [33:0] m10_reg;
  logic [33:0] m01_reg;

  state_t      state_reg;
  logic [5:0]  iter_reg;
  logic [21:0] den_reg;
  // Lane 0 divides sum(x), lane 1 divides sum(y); the dividend register
  // shifts out from the top while quotient bits shift in at the bottom.
  logic [33:0] num_reg  [2];
  logic [21:0] rem_reg  [2];
  logic [33:0] num_next [2];
  logic [21:0] rem_next [2];

  assign cb   = pixel_YCbCr[15:8];
  assign cr   = pixel_YCbCr[7:0];
  assign mask = de_in && (cb >= CB_MIN) && (cb <= CB_MAX)
                      && (cr >= CR_MIN) && (cr <= CR_MAX);

  // The registered pass-through copies double as the previous-cycle values.
  assign frame_end = v_sync_in && !v_sync_out;
  assign de_fall   = !de_in && de_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      de_out     <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
      pixel_mask <= 24'h000000;
    end else begin
      de_out     <= de_in;
      h_sync_out <= h_sync_in;
      v_sync_out <= v_sync_in;
      pixel_mask <= {24{mask}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg   <= '0;
      y_reg   <= '0;
      m00_reg <= '0;
      m10_reg <= '0;
      m01_reg <= '0;
    end else if (frame_end) begin
      // A mask pixel coinciding with the frame end opens the next frame.
      x_reg   <= '0;
      y_reg   <= '0;
      m00_reg <= {21'b0, mask};
      m10_reg <= mask ? {23'b0, x_reg} : '0;
      m01_reg <= mask ? {23'b0, y_reg} : '0;
    end else begin
      if (de_in) begin
        x_reg <= x_reg + 11'd1;
      end else if (de_fall) begin
        x_reg <= '0;
        y_reg <= y_reg + 11'd1;
      end
      if (mask) begin
        m00_reg <= m00_reg + 22'd1;
        m10_reg <= m10_reg + {23'b0, x_reg};
        m01_reg <= m01_reg + {23'b0, y_reg};
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [22:0] shifted;
      logic        fits;
      assign shifted      = {rem_reg[gi], num_reg[gi][33]};
      assign fits         = shifted >= {1'b0, den_reg};
      assign rem_next[gi] = 22'(fits ? (shifted - {1'b0, den_reg}) : shifted);
      assign num_next[gi] = {num_reg[gi][32:0], fits};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      iter_reg       <= '0;
      den_reg        <= '0;
      num_reg[0]     <= '0;
      num_reg[1]     <= '0;
      rem_reg[0]     <= '0;
      rem_reg[1]     <= '0;
      centroid_x     <= '0;
      centroid_y     <= '0;
      centroid_valid <= 1'b0;
      object_found   <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      centroid_valid <= 1'b0;
      overrun        <= frame_end && (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (frame_end) begin
            den_reg    <= m00_reg;
            num_reg[0] <= m10_reg;
            num_reg[1] <= m01_reg;
            rem_reg[0] <= '0;
            rem_reg[1] <= '0;
            iter_reg   <= '0;
            state_reg  <= (m00_reg != '0) ? DIV : DONE;
          end
        end
        DIV: begin
          for (int i = 0; i < 2; i++) begin
            num_reg[i] <= num_next[i];
            rem_reg[i] <= rem_next[i];
          end
          iter_reg <= iter_reg + 6'd1;
          if (iter_reg == 6'd33) state_reg <= DONE;
        end
        DONE: begin
          centroid_valid <= 1'b1;
          if (den_reg != '0) begin
            centroid_x   <= num_reg[0][10:0];
            centroid_y   <= num_reg[1][10:0];
            object_found <= 1'b1;
          end else begin
            object_found <= 1'b0;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ycbcr_skin_centroid.sv
// Bench for ycbcr_skin_centroid: pass-through scoreboard per pixel plus a
// frame-level model whose predicted centroid results are checked on publication.
module tb_ycbcr_skin_centroid;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        de_in = 1'b0;
  logic        h_sync_in = 1'b0;
  logic        v_sync_in = 1'b0;
  logic [23:0] pixel_YCbCr = 24'h0;
  logic        de_out, h_sync_out, v_sync_out;
  logic [23:0] pixel_mask;
  logic [10:0] centroid_x, centroid_y;
  logic        centroid_valid, object_found, overrun;

  ycbcr_skin_centroid dut (
    .clk(clk), .rst(rst), .de_in(de_in), .h_sync_in(h_sync_in),
    .v_sync_in(v_sync_in), .pixel_YCbCr(pixel_YCbCr),
    .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
    .pixel_mask(pixel_mask), .centroid_x(centroid_x), .centroid_y(centroid_y),
    .centroid_valid(centroid_valid), .object_found(object_found), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {logic de; logic hs; logic vs; logic [23:0] mask;} pt_t;
  typedef struct {logic [10:0] x; logic [10:0] y; logic found; int due;} res_t;
  typedef struct {logic de; logic hs; logic [23:0] pix; logic [23:0] exp_mask;} vec_t;

  pt_t  pt_q[$];
  res_t res_q[$];
  int   ovr_q[$];
  vec_t tbl[10];

  int          bx, by, last_due;
  bit          pde, pvs;
  longint      s00, s10, s01;
  logic [10:0] last_x, last_y;

  localparam logic [23:0] SKIN = {8'd170, 8'd100, 8'd150};
  localparam logic [23:0] NONSKIN = {8'd170, 8'd69, 8'd139};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic skin(input logic [23:0] p);
    return (p[15:8] >= 8'd77) && (p[15:8] <= 8'd127) && (p[7:0] >= 8'd133) && (p[7:0] <= 8'd173);
  endfunction

  task automatic model_clear();
    bx = 0; by = 0; pde = 0; pvs = 0; s00 = 0; s10 = 0; s01 = 0;
    last_due = 0; last_x = '0; last_y = '0;
    pt_q.delete(); res_q.delete(); ovr_q.delete();
  endtask

  // One input cycle: check the previous cycle's pass-through, drive, update the model.
  task automatic tick(input logic de, input logic hs, input logic vs,
                      input logic [23:0] pix, input logic m);
    pt_t  e;
    res_t r;
    int   e_cyc;
    @(negedge clk);
    if (pt_q.size() > 0) begin
      e = pt_q.pop_front();
      check("passthru", 64'({de_out, h_sync_out, v_sync_out, pixel_mask}),
            64'({e.de, e.hs, e.vs, e.mask}));
    end
    de_in = de; h_sync_in = hs; v_sync_in = vs; pixel_YCbCr = pix;
    pt_q.push_back('{de, hs, vs, m ? 24'hFFFFFF : 24'h0});
    if (vs && !pvs) begin
      e_cyc = cyc + 1;
      if (e_cyc <= last_due) begin
        ovr_q.push_back(e_cyc);
      end else begin
        if (s00 > 0) begin
          r.x = 11'(s10 / s00); r.y = 11'(s01 / s00); r.found = 1'b1; r.due = e_cyc + 35;
          last_x = r.x; last_y = r.y;
        end else begin
          r.x = last_x; r.y = last_y; r.found = 1'b0; r.due = e_cyc + 1;
        end
        last_due = r.due;
        res_q.push_back(r);
      end
      s00 = m ? 1 : 0; s10 = m ? bx : 0; s01 = m ? by : 0;
      bx = 0; by = 0;
    end else begin
      if (m) begin s00++; s10 += bx; s01 += by; end
      if (de) bx++;
      else if (pde) begin bx = 0; by++; end
    end
    pde = de; pvs = vs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 24'h0, 0);
  endtask

  task automatic frame_end();
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 24'h0, 0);
    idle(2);
  endtask

  // mode 0: all skin, 1: only (px,py), 2: none, 3: random, 4: even x skin
  task automatic send_frame(input int lines, input int width, input int mode,
                            input int px, input int py);
    logic [23:0] p;
    for (int l = 0; l < lines; l++) begin
      tick(0, 1, 0, 24'h0, 0);
      tick(0, 1, 0, 24'h0, 0);
      for (int x = 0; x < width; x++) begin
        case (mode)
          0: p = SKIN;
          1: p = (x == px && l == py) ? SKIN : NONSKIN;
          3: p = {8'($urandom_range(0, 255)), 8'($urandom_range(60, 140)), 8'($urandom_range(120, 190))};
          4: p = (x % 2 == 0) ? SKIN : NONSKIN;
          default: p = NONSKIN;
        endcase
        tick(1, 0, 0, p, skin(p));
      end
      idle(2);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    de_in = 1'($urandom); h_sync_in = 1'($urandom); v_sync_in = 1'($urandom);
    pixel_YCbCr = 24'($urandom);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("reset_outputs", 64'({de_out, h_sync_out, v_sync_out, pixel_mask, centroid_x,
            centroid_y, centroid_valid, object_found, overrun}), 64'h0);
      de_in = 1'($urandom); h_sync_in = 1'($urandom); v_sync_in = 1'($urandom);
      pixel_YCbCr = 24'($urandom);
    end
    rst = 1'b0;
    de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0; pixel_YCbCr = 24'h0;
  endtask

  // Result monitor: every publication and overrun pulse must match the model.
  always @(negedge clk) begin : mon
    res_t r;
    if (!rst) begin
      if (res_q.size() > 0 && cyc > res_q[0].due) begin
        check("valid_missing", 64'(cyc), 64'(res_q[0].due));
        r = res_q.pop_front();
      end
      if (centroid_valid) begin
        if (res_q.size() == 0) begin
          check("valid_spurious", 64'(centroid_valid), 64'h0);
        end else begin
          r = res_q.pop_front();
          check("valid_cycle", 64'(cyc), 64'(r.due));
          check("centroid_x", 64'(centroid_x), 64'(r.x));
          check("centroid_y", 64'(centroid_y), 64'(r.y));
          check("object_found", 64'(object_found), 64'(r.found));
        end
      end
      if (ovr_q.size() > 0 && cyc > ovr_q[0]) begin
        check("overrun_missing", 64'(cyc), 64'(ovr_q[0]));
        void'(ovr_q.pop_front());
      end
      if (ovr_q.size() > 0 && ovr_q[0] == cyc) begin
        void'(ovr_q.pop_front());
        check("overrun", 64'(overrun), 64'h1);
      end else if (overrun) begin
        check("overrun_spurious", 64'(overrun), 64'h0);
      end
    end
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, {8'd170, 8'd69, 8'd139}, 24'h000000};
    tbl[1] = '{1'b1, 1'b1, {8'd170, 8'd100, 8'd150}, 24'hFFFFFF};
    tbl[2] = '{1'b1, 1'b0, {8'd0, 8'd77, 8'd133}, 24'hFFFFFF};
    tbl[3] = '{1'b1, 1'b0, {8'd255, 8'd127, 8'd173}, 24'hFFFFFF};
    tbl[4] = '{1'b1, 1'b0, {8'd128, 8'd76, 8'd150}, 24'h000000};
    tbl[5] = '{1'b1, 1'b1, {8'd128, 8'd128, 8'd150}, 24'h000000};
    tbl[6] = '{1'b1, 1'b0, {8'd128, 8'd100, 8'd132}, 24'h000000};
    tbl[7] = '{1'b1, 1'b0, {8'd128, 8'd100, 8'd174}, 24'h000000};
    tbl[8] = '{1'b0, 1'b1, {8'd170, 8'd100, 8'd150}, 24'h000000};
    tbl[9] = '{1'b0, 1'b0, 24'h000000, 24'h000000};

    // Reset under random input, then the first pixel must land at x=0.
    do_reset(3);
    send_frame(1, 3, 4, 0, 0);
    frame_end();
    idle(40);
    check("first_frame_x", 64'(centroid_x), 64'd1);

    // Mask thresholds and pass-through latency.
    for (int i = 0; i < 10; i++) tick(tbl[i].de, tbl[i].hs, 1'b0, tbl[i].pix, tbl[i].exp_mask[0]);
    frame_end();
    idle(40);

    // Full 4x8 skin frame.
    send_frame(4, 8, 0, 0, 0);
    frame_end();
    idle(40);
    check("full_frame_xy", 64'({centroid_x, centroid_y, object_found}), 64'({11'd3, 11'd1, 1'b1}));

    // Single pixel, then an empty frame that keeps the centroid.
    send_frame(4, 8, 1, 5, 2);
    frame_end();
    idle(40);
    check("single_px_xy", 64'({centroid_x, centroid_y, object_found}), 64'({11'd5, 11'd2, 1'b1}));
    send_frame(4, 8, 2, 0, 0);
    frame_end();
    idle(10);
    check("empty_frame", 64'({centroid_x, centroid_y, object_found}), 64'({11'd5, 11'd2, 1'b0}));

    // Second frame end while dividing: overrun, its data discarded.
    send_frame(4, 8, 3, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 24'h0, 0);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, SKIN, 1);
    idle(2);
    tick(0, 0, 1, 24'h0, 0);
    tick(0, 0, 1, 24'h0, 0);
    idle(50);
    send_frame(2, 4, 1, 1, 1);
    frame_end();
    idle(40);
    check("after_overrun_xy", 64'({centroid_x, centroid_y}), 64'({11'd1, 11'd1}));

    // Reset in the middle of a division, then a clean frame.
    send_frame(3, 5, 0, 0, 0);
    frame_end();
    idle(16);
    do_reset(2);
    idle(40);
    send_frame(4, 8, 3, 0, 0);
    frame_end();
    idle(45);

    check("pending_results", 64'(res_q.size()), 64'h0);
    check("pending_overruns", 64'(ovr_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
